// File: rtl/isa_hs_pkg.sv
// Shared ISA definitions for the handshake execution unit: opcodes, FSM states
// and instruction field positions.
package isa_hs_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_MOVI  = 4'h1,
    OP_LOAD  = 4'h2,
    OP_STORE = 4'h3,
    OP_ADD   = 4'h4,
    OP_ADDI  = 4'h5,
    OP_SUB   = 4'h6,
    OP_SUBI  = 4'h7,
    OP_JZ    = 4'h8,
    OP_JNZ   = 4'h9,
    OP_JC    = 4'hA,
    OP_JMP   = 4'hB,
    OP_HALT  = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    FETCH_HI,
    FETCH_LO,
    EXECUTE,
    MEM,
    HALTED
  } state_e;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 6;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 2;
  localparam int RS2_LO = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  localparam int REG_AW = 3;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two combinational read ports, one synchronous write port.
// Asynchronous reset clears every entry.
module regfile_2r1w #(
  parameter int DATA_BITS = 8,
  parameter int NUM_REGS  = 8,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        raddr_a_i,
  output logic [DATA_BITS-1:0] rdata_a_o,
  input  logic [AW-1:0]        raddr_b_i,
  output logic [DATA_BITS-1:0] rdata_b_o,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [DATA_BITS-1:0] wdata_i
);

  logic [DATA_BITS-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/exec_unit_hs.sv
// Multi-cycle core: two byte fetches, one execute cycle, optional memory cycle.
// 3 cycles per instruction (4 for LOAD/STORE) with ack high; each ack wait stalls one cycle.
module exec_unit_hs
  import isa_hs_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int NUM_REGS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 halted,
  output logic                 illegal,
  output logic [ADDR_BITS-1:0] pc_out,
  output logic [1:0]           flags_out
);

  localparam int DW1 = DATA_BITS + 1;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] pc_q, pc_d;
  logic [15:0]          ir_q, ir_d;
  logic                 z_q, z_d, c_q, c_d;
  logic                 halted_q, halted_d, illegal_q, illegal_d;

  op_e                  op;
  logic [REG_AW-1:0]    rd, rs1, rs2, ra_a, ra_b;
  logic [DATA_BITS-1:0] imm_data, rf_a, rf_b, alu_b, rf_wdata;
  logic [ADDR_BITS-1:0] imm_addr;
  logic [DW1-1:0]       alu_sum;
  logic                 sub_op, use_imm, rf_we, req_int;
  logic                 unused_ir_bit;

  assign op       = op_e'(ir_q[OP_HI:OP_LO]);
  assign rd       = ir_q[RD_HI:RD_LO];
  assign rs1      = ir_q[RS1_HI:RS1_LO];
  assign rs2      = ir_q[RS2_HI:RS2_LO];
  assign imm_data = DATA_BITS'(ir_q[IMM_HI:IMM_LO]);
  assign imm_addr = ADDR_BITS'(ir_q[IMM_HI:IMM_LO]);
  assign unused_ir_bit = ir_q[11];

  // Immediate forms and STORE address rd through the read ports instead of rs1/rs2.
  assign use_imm = (op == OP_ADDI) || (op == OP_SUBI);
  assign sub_op  = (op == OP_SUB)  || (op == OP_SUBI);
  assign ra_a    = use_imm ? rd : rs1;
  assign ra_b    = (op == OP_STORE) ? rd : rs2;

  regfile_2r1w #(.DATA_BITS(DATA_BITS), .NUM_REGS(NUM_REGS)) u_rf (
    .clk       (clk),
    .reset     (reset),
    .raddr_a_i (ra_a),
    .rdata_a_o (rf_a),
    .raddr_b_i (ra_b),
    .rdata_b_o (rf_b),
    .we_i      (rf_we),
    .waddr_i   (rd),
    .wdata_i   (rf_wdata)
  );

  // Single adder; subtraction is a + ~b + 1 so carry-out means "no borrow".
  assign alu_b   = use_imm ? imm_data : rf_b;
  assign alu_sum = {1'b0, rf_a} + {1'b0, (sub_op ? ~alu_b : alu_b)} + DW1'(sub_op);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    z_d       = z_q;
    c_d       = c_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    rf_wdata  = alu_sum[DATA_BITS-1:0];
    req_int   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = '0;
    case (state_q)
      FETCH_HI: begin
        req_int = 1'b1;
        if (mem_ack) begin
          ir_d[15:8] = mem_rdata[7:0];
          state_d    = FETCH_LO;
        end
      end
      FETCH_LO: begin
        req_int  = 1'b1;
        mem_addr = pc_q + ADDR_BITS'(1);
        if (mem_ack) begin
          ir_d[7:0] = mem_rdata[7:0];
          state_d   = EXECUTE;
        end
      end
      EXECUTE: begin
        state_d = FETCH_HI;
        pc_d    = pc_q + ADDR_BITS'(2);
        case (op)
          OP_NOP: ;
          OP_MOVI: begin
            rf_we    = 1'b1;
            rf_wdata = imm_data;
          end
          OP_LOAD, OP_STORE: begin
            state_d = MEM;
            pc_d    = pc_q;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
            rf_we = 1'b1;
            z_d   = (alu_sum[DATA_BITS-1:0] == '0);
            c_d   = alu_sum[DATA_BITS];
          end
          OP_JZ:  if (z_q)  pc_d = imm_addr;
          OP_JNZ: if (!z_q) pc_d = imm_addr;
          OP_JC:  if (c_q)  pc_d = imm_addr;
          OP_JMP: pc_d = imm_addr;
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = HALTED;
            pc_d     = pc_q;
          end
          default: begin
            illegal_d = 1'b1;
            halted_d  = 1'b1;
            state_d   = HALTED;
            pc_d      = pc_q;
          end
        endcase
      end
      MEM: begin
        req_int  = 1'b1;
        mem_addr = imm_addr;
        mem_we   = (op == OP_STORE);
        if (op == OP_STORE) mem_wdata = rf_b;
        if (mem_ack) begin
          if (op == OP_LOAD) begin
            rf_we    = 1'b1;
            rf_wdata = mem_rdata;
          end
          pc_d    = pc_q + ADDR_BITS'(2);
          state_d = FETCH_HI;
        end
      end
      HALTED: ;
      default: state_d = FETCH_HI;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH_HI;
      pc_q      <= '0;
      ir_q      <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      z_q       <= z_d;
      c_q       <= c_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset lands in FETCH_HI, so the request is masked while reset is held.
  assign mem_req   = req_int && !reset;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign pc_out    = pc_q;
  assign flags_out = {z_q, c_q};

endmodule
